mips_multicycle_ctrl: RTL and testbench

- Moore FSM that sequences a multicycle MIPS datapath: one shared memory for instructions and data, one ALU, instruction register (IR), and the A/B/ALUOut holding registers.
- Decodes opcode/funct from the IR and drives every datapath select and enable, one micro-step per clock.
- Handles memory wait-states through a ready handshake.
- Replaces the single-cycle decode path when the datapath is built multicycle.

---
 rtl/mips_multicycle_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch, decode and execute
// micro-steps over a shared memory, one ALU and the IR/A/B/ALUOut registers.
module mips_multicycle_ctrl #(
  parameter int ALU_W = 4,
  parameter int ST_W  = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pcen,
  output logic             iord,
  output logic             irwrite,
  output logic             memwrite,
  output logic             regdst,
  output logic             memtoreg,
  output logic             regwrite,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       pcsrc,
  output logic [ALU_W-1:0] alucontrol,
  output logic             illegal_op,
  output logic [ST_W-1:0]  state
);

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_RTYPEEX = 4'd6;
  localparam logic [3:0] S_RTYPEWB = 4'd7;
  localparam logic [3:0] S_BEQEX   = 4'd8;
  localparam logic [3:0] S_ADDIEX  = 4'd9;
  localparam logic [3:0] S_ADDIWB  = 4'd10;
  localparam logic [3:0] S_JEX     = 4'd11;
  localparam logic [3:0] S_BNEEX   = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  logic [3:0] state_q, state_d;
  logic       ill_q, ill_d;
  logic [3:0] fn_alu;
  logic       fn_ok;
  logic [3:0] alu_c;

  // funct decode for R-type ALU operations
  always_comb begin
    fn_alu = ALU_ADD;
    fn_ok  = 1'b1;
    case (funct)
      6'b100000: fn_alu = ALU_ADD;
      6'b100010: fn_alu = ALU_SUB;
      6'b100100: fn_alu = ALU_AND;
      6'b100101: fn_alu = ALU_OR;
      6'b101010: fn_alu = ALU_SLT;
      6'b100111: fn_alu = ALU_NOR;
      default:   fn_ok  = 1'b0;
    endcase
  end

  // next-state and illegal-encoding detection
  always_comb begin
    state_d = S_FETCH;
    ill_d   = 1'b0;
    case (state_q)
      S_FETCH:   state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_BNE:       state_d = S_BNEEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
          default: begin
            state_d = S_FETCH;
            ill_d   = 1'b1;
          end
        endcase
      end
      S_MEMADR:  state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:   state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_RTYPEEX: begin
        state_d = fn_ok ? S_RTYPEWB : S_FETCH;
        ill_d   = ~fn_ok;
      end
      S_ADDIEX:  state_d = S_ADDIWB;
      default:   state_d = S_FETCH;
    endcase
  end

  // state and illegal pulse registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ill_q   <= ill_d;
    end
  end

  // Moore datapath controls; pcen/irwrite also gate on ready/zero
  always_comb begin
    pcen     = 1'b0;
    iord     = 1'b0;
    irwrite  = 1'b0;
    memwrite = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    alu_c    = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        alusrcb = 2'b01;
        irwrite = mem_ready;
        pcen    = mem_ready;
      end
      S_DECODE:  alusrcb = 2'b11;
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD:   iord = 1'b1;
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        alu_c   = fn_alu;
      end
      S_RTYPEWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      S_BEQEX, S_BNEEX: begin
        alusrca = 1'b1;
        alu_c   = ALU_SUB;
        pcsrc   = 2'b01;
        pcen    = (state_q == S_BEQEX) ? zero : ~zero;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_ADDIWB:  regwrite = 1'b1;
      S_JEX: begin
        pcsrc = 2'b10;
        pcen  = 1'b1;
      end
      default: ;
    endcase
  end

  assign alucontrol = ALU_W'(alu_c);
  assign illegal_op = ill_q;
  assign state      = ST_W'(state_q);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl with an expected-vector queue.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       pcen, iord, irwrite, memwrite, regdst, memtoreg;
  logic       regwrite, alusrca, illegal_op;
  logic [1:0] alusrcb, pcsrc;
  logic [3:0] alucontrol, state;

  int checks = 0;
  int failures = 0;
  logic [20:0] sb[$];

  mips_multicycle_ctrl #(.ALU_W(4), .ST_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct),
    .zero(zero), .mem_ready(mem_ready), .pcen(pcen), .iord(iord),
    .irwrite(irwrite), .memwrite(memwrite), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol),
    .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  // {state, pcen,iord,irwrite,memwrite,regdst,memtoreg,regwrite,alusrca,
  //  alusrcb, pcsrc, alucontrol, illegal_op}
  function automatic logic [20:0] ev(
    input logic [3:0] st, input logic [7:0] f,
    input logic [1:0] asb, input logic [1:0] ps,
    input logic [3:0] alu, input logic ill);
    return {st, f, asb, ps, alu, ill};
  endfunction

  function automatic logic [20:0] fetch(input logic mr, input logic ill);
    return ev(4'd0, {mr, 1'b0, mr, 5'b0}, 2'b01, 2'b00, 4'b0010, ill);
  endfunction

  logic [20:0] DEC, MA, MR, MWB, MWR, RWB, AEX, AWB, JX;
  initial begin
    DEC = ev(4'd1, 8'b0000_0000, 2'b11, 2'b00, 4'b0010, 1'b0);
    MA  = ev(4'd2, 8'b0000_0001, 2'b10, 2'b00, 4'b0010, 1'b0);
    MR  = ev(4'd3, 8'b0100_0000, 2'b00, 2'b00, 4'b0010, 1'b0);
    MWB = ev(4'd4, 8'b0000_0110, 2'b00, 2'b00, 4'b0010, 1'b0);
    MWR = ev(4'd5, 8'b0101_0000, 2'b00, 2'b00, 4'b0010, 1'b0);
    RWB = ev(4'd7, 8'b0000_1010, 2'b00, 2'b00, 4'b0010, 1'b0);
    AEX = ev(4'd9, 8'b0000_0001, 2'b10, 2'b00, 4'b0010, 1'b0);
    AWB = ev(4'd10, 8'b0000_0010, 2'b00, 2'b00, 4'b0010, 1'b0);
    JX  = ev(4'd11, 8'b1000_0000, 2'b00, 2'b10, 4'b0010, 1'b0);
  end

  function automatic logic [20:0] rex(input logic [3:0] alu);
    return ev(4'd6, 8'b0000_0001, 2'b00, 2'b00, alu, 1'b0);
  endfunction

  function automatic logic [20:0] br(input logic [3:0] st,
                                     input logic pc);
    return ev(st, {pc, 7'b000_0001}, 2'b00, 2'b01, 4'b0110, 1'b0);
  endfunction

  // drive one cycle of inputs, queue its expectation, compare mid-cycle
  task automatic cyc(input logic mr, input logic z,
                     input logic [20:0] e, input string tag);
    logic [20:0] obs, exp_v;
    mem_ready = mr;
    zero = z;
    sb.push_back(e);
    #1;
    obs = {state, pcen, iord, irwrite, memwrite, regdst, memtoreg,
           regwrite, alusrca, alusrcb, pcsrc, alucontrol, illegal_op};
    exp_v = sb.pop_front();
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0;
    opcode = 6'b0;
    funct = 6'b0;
    zero = 1'b0;
    mem_ready = 1'b0;
    cyc(1'b0, 1'b0, fetch(1'b0, 1'b0), "reset");
    reset_n = 1'b1;

    // lw with a fetch wait, then memory read wait
    opcode = 6'b100011;
    cyc(1'b0, 1'b0, fetch(1'b0, 1'b0), "lw_fwait");
    cyc(1'b1, 1'b0, fetch(1'b1, 1'b0), "lw_f");
    cyc(1'b1, 1'b0, DEC, "lw_dec");
    cyc(1'b1, 1'b0, MA, "lw_adr");
    cyc(1'b1, 1'b0, MR, "lw_rd");
    cyc(1'b1, 1'b0, MWB, "lw_wb");

    // sw with two wait cycles in MEMWR
    opcode = 6'b101011;
    cyc(1'b1, 1'b0, fetch(1'b1, 1'b0), "sw_f");
    cyc(1'b1, 1'b0, DEC, "sw_dec");
    cyc(1'b1, 1'b0, MA, "sw_adr");
    cyc(1'b0, 1'b0, MWR, "sw_wr0");
    cyc(1'b0, 1'b0, MWR, "sw_wr1");
    cyc(1'b1, 1'b0, MWR, "sw_wr2");

    // R-type sub and slt
    opcode = 6'b000000;
    funct = 6'b100010;
    cyc(1'b1, 1'b0, fetch(1'b1, 1'b0), "sub_f");
    cyc(1'b1, 1'b0, DEC, "sub_dec");
    cyc(1'b1, 1'b0, rex(4'b0110), "sub_ex");
    cyc(1'b1, 1'b0, RWB, "sub_wb");
    funct = 6'b101010;
    cyc(1'b1, 1'b0, fetch(1'b1, 1'b0), "slt_f");
    cyc(1'b1, 1'b0, DEC, "slt_dec");
    cyc(1'b1, 1'b0, rex(4'b0111), "slt_ex");
    cyc(1'b1, 1'b0, RWB, "slt_wb");
    funct = 6'b100111;
    cyc(1'b1, 1'b0, fetch(1'b1, 1'b0), "nor_f");
    cyc(1'b1, 1'b0, DEC, "nor_dec");
    cyc(1'b1, 1'b0, rex(4'b1100), "nor_ex");
    cyc(1'b1, 1'b0, RWB, "nor_wb");

    // addi
    opcode = 6'b001000;
    cyc(1'b1, 1'b0, fetch(1'b1, 1'b0), "addi_f");
    cyc(1'b1, 1'b0, DEC, "addi_dec");
    cyc(1'b1, 1'b0, AEX, "addi_ex");
    cyc(1'b1, 1'b0, AWB, "addi_wb");

    // branches
    opcode = 6'b000100;
    cyc(1'b1, 1'b0, fetch(1'b1, 1'b0), "beq1_f");
    cyc(1'b1, 1'b0, DEC, "beq1_dec");
    cyc(1'b1, 1'b1, br(4'd8, 1'b1), "beq_taken");
    cyc(1'b1, 1'b0, fetch(1'b1, 1'b0), "beq0_f");
    cyc(1'b1, 1'b0, DEC, "beq0_dec");
    cyc(1'b1, 1'b0, br(4'd8, 1'b0), "beq_not");
    opcode = 6'b000101;
    cyc(1'b1, 1'b0, fetch(1'b1, 1'b0), "bne0_f");
    cyc(1'b1, 1'b0, DEC, "bne0_dec");
    cyc(1'b1, 1'b0, br(4'd12, 1'b1), "bne_taken");
    cyc(1'b1, 1'b0, fetch(1'b1, 1'b0), "bne1_f");
    cyc(1'b1, 1'b0, DEC, "bne1_dec");
    cyc(1'b1, 1'b1, br(4'd12, 1'b0), "bne_not");

    // jump
    opcode = 6'b000010;
    cyc(1'b1, 1'b0, fetch(1'b1, 1'b0), "j_f");
    cyc(1'b1, 1'b0, DEC, "j_dec");
    cyc(1'b1, 1'b0, JX, "j_ex");

    // illegal opcode: one-cycle pulse in the following FETCH
    opcode = 6'b111111;
    cyc(1'b1, 1'b0, fetch(1'b1, 1'b0), "ill_f");
    cyc(1'b1, 1'b0, DEC, "ill_dec");
    opcode = 6'b000000;
    funct = 6'b000111;
    cyc(1'b1, 1'b0, fetch(1'b1, 1'b1), "ill_pulse");
    cyc(1'b1, 1'b0, DEC, "badfn_dec");
    cyc(1'b1, 1'b0, rex(4'b0010), "badfn_ex");
    cyc(1'b0, 1'b0, fetch(1'b0, 1'b1), "badfn_pulse");
    cyc(1'b0, 1'b0, fetch(1'b0, 1'b0), "pulse_end");

    // asynchronous reset in the middle of a store
    opcode = 6'b101011;
    cyc(1'b1, 1'b0, fetch(1'b1, 1'b0), "rst_sw_f");
    cyc(1'b1, 1'b0, DEC, "rst_sw_dec");
    cyc(1'b1, 1'b0, MA, "rst_sw_adr");
    mem_ready = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    cyc(1'b0, 1'b0, fetch(1'b0, 1'b0), "rst_mid_memwr");
    reset_n = 1'b1;
    cyc(1'b1, 1'b0, fetch(1'b1, 1'b0), "post_rst_f");
    cyc(1'b1, 1'b0, DEC, "post_rst_dec");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
